// File: rtl/msg_pager.sv
// rtl/msg_pager.sv - paged 7-segment message composer with BCD value, status glyphs and blinking alarm
module msg_pager #(
   parameter int DIGITS   = 4,
   parameter int BIN_W    = 8,
   parameter int DWELL    = 134217728,
   parameter int BLINK    = 16777216,
   parameter int ALARM_TH = 50
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  mode_i,
   input  logic [3:0]            state1_i,
   input  logic [3:0]            state2_i,
   input  logic [BIN_W-1:0]      value_i,
   output logic [8*DIGITS-1:0]   seg_o
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SR_W  = BCD_W + BIN_W;
   localparam int SC_W  = $clog2(BIN_W + 1);
   localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int BL_W  = (BLINK > 1) ? $clog2(BLINK) : 1;
   localparam logic [31:0]      ALARM_V  = 32'(ALARM_TH);
   localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL - 1);
   localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK - 1);
   localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(BIN_W - 1);

   typedef enum logic [1:0] {
      C_IDLE  = 2'd0,
      C_SHIFT = 2'd1,
      C_DONE  = 2'd2
   } conv_state_t;

   // digit and hex-letter glyphs, segments a..g, active-low
   function automatic logic [6:0] hex7(input logic [3:0] code);
      logic [6:0] g;
      case (code)
         4'h0:    g = 7'b0000001;
         4'h1:    g = 7'b1001111;
         4'h2:    g = 7'b0010010;
         4'h3:    g = 7'b0000110;
         4'h4:    g = 7'b1001100;
         4'h5:    g = 7'b0100100;
         4'h6:    g = 7'b0100000;
         4'h7:    g = 7'b0001111;
         4'h8:    g = 7'b0000000;
         4'h9:    g = 7'b0000100;
         4'hA:    g = 7'b0001000;
         4'hB:    g = 7'b1100000;
         4'hC:    g = 7'b0110001;
         4'hD:    g = 7'b1000010;
         4'hE:    g = 7'b0110000;
         default: g = 7'b0111000;
      endcase
      return g;
   endfunction

   // state code 0 means "no state" and shows a dash instead of a zero
   function automatic logic [6:0] state7(input logic [3:0] code);
      return (code == 4'h0) ? 7'b1111110 : hex7(code);
   endfunction

   // one double-dabble step: adjust every BCD nibble >= 5, then shift left
   function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] s);
      logic [SR_W-1:0] t;
      t = s;
      for (int i = 0; i < DIGITS; i++) begin
         if (t[BIN_W+4*i +: 4] >= 4'd5)
            t[BIN_W+4*i +: 4] = t[BIN_W+4*i +: 4] + 4'd3;
      end
      return {t[SR_W-2:0], 1'b0};
   endfunction

   logic [BIN_W-1:0]  value_q;
   logic [3:0]        state1_q, state2_q;
   logic              mode_q;
   logic [8:0]        key_now, key_prev_q;
   logic              restart;

   conv_state_t       conv_q, conv_d;
   logic [SR_W-1:0]   sr_q, sr_d;
   logic [SC_W-1:0]   shift_cnt_q, shift_cnt_d;
   logic [BIN_W-1:0]  conv_src_q, conv_src_d;
   logic              pending_first_q, pending_first_d;
   logic [BCD_W-1:0]  bcd_q, bcd_d;

   logic [DW_W-1:0]   dwell_cnt;
   logic              page;
   logic              alarm_now, alarm_q;
   logic [BL_W-1:0]   blink_cnt;
   logic              blink_on;

   logic [8*DIGITS-1:0] status_bus, value_bus, alarm_bus, seg_next;
   logic                lead_zero;

   assign key_now   = {state2_q, state1_q, mode_q};
   assign restart   = (key_now != key_prev_q);
   assign alarm_now = (state1_q == 4'h0) && (state2_q == 4'h0) && (32'(value_q) >= ALARM_V);

   // input capture; everything downstream works on these copies
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         value_q    <= '0;
         state1_q   <= '0;
         state2_q   <= '0;
         mode_q     <= 1'b0;
         key_prev_q <= '0;
      end else begin
         value_q    <= value_i;
         state1_q   <= state1_i;
         state2_q   <= state2_i;
         mode_q     <= mode_i;
         key_prev_q <= key_now;
      end
   end

   // converter state and datapath registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         conv_q          <= C_IDLE;
         sr_q            <= '0;
         shift_cnt_q     <= '0;
         conv_src_q      <= '0;
         pending_first_q <= 1'b1;
         bcd_q           <= '0;
      end else begin
         conv_q          <= conv_d;
         sr_q            <= sr_d;
         shift_cnt_q     <= shift_cnt_d;
         conv_src_q      <= conv_src_d;
         pending_first_q <= pending_first_d;
         bcd_q           <= bcd_d;
      end
   end

   // converter next state: a started run always completes, bcd_q only moves in DONE
   always_comb begin
      conv_d          = conv_q;
      sr_d            = sr_q;
      shift_cnt_d     = shift_cnt_q;
      conv_src_d      = conv_src_q;
      pending_first_d = pending_first_q;
      bcd_d           = bcd_q;
      case (conv_q)
         C_IDLE: begin
            if ((value_q != conv_src_q) || pending_first_q) begin
               sr_d            = {{BCD_W{1'b0}}, value_q};
               conv_src_d      = value_q;
               pending_first_d = 1'b0;
               shift_cnt_d     = '0;
               conv_d          = C_SHIFT;
            end
         end
         C_SHIFT: begin
            sr_d        = dabble(sr_q);
            shift_cnt_d = shift_cnt_q + SC_W'(1);
            if (shift_cnt_q == SC_LAST)
               conv_d = C_DONE;
         end
         C_DONE: begin
            bcd_d  = sr_q[SR_W-1 -: BCD_W];
            conv_d = C_IDLE;
         end
         default: conv_d = C_IDLE;
      endcase
   end

   // page dwell timer; a state/mode change restarts on the status page
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dwell_cnt <= '0;
         page      <= 1'b0;
      end else if (restart) begin
         dwell_cnt <= '0;
         page      <= 1'b0;
      end else if (dwell_cnt == DW_LAST) begin
         dwell_cnt <= '0;
         page      <= ~page;
      end else begin
         dwell_cnt <= dwell_cnt + DW_W'(1);
      end
   end

   // alarm register and blink phase; a fresh alarm always starts in the on phase
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         alarm_q   <= 1'b0;
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else begin
         alarm_q <= alarm_now;
         if (alarm_now && !alarm_q) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
         end else if (blink_cnt == BL_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
         end else begin
            blink_cnt <= blink_cnt + BL_W'(1);
         end
      end
   end

   // page composition and alarm override
   always_comb begin
      status_bus = '1;
      status_bus[8*(DIGITS-1) +: 8] = {state7(state2_q), mode_q};
      status_bus[8 +: 8]            = {state7(state1_q), ~mode_q};

      value_bus = '1;
      lead_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (lead_zero && (bcd_q[4*i +: 4] == 4'h0) && (i != 0)) begin
            value_bus[8*i +: 8] = 8'hFF;
         end else begin
            value_bus[8*i +: 8] = {hex7(bcd_q[4*i +: 4]), 1'b1};
            lead_zero = 1'b0;
         end
      end

      alarm_bus = '1;
      if (blink_on) begin
         alarm_bus[8*(DIGITS-1) +: 8] = 8'b11010001;
         alarm_bus[8*(DIGITS-2) +: 8] = 8'b11000101;
         alarm_bus[8*(DIGITS-3) +: 8] = 8'b11100001;
      end

      if (alarm_q)
         seg_next = alarm_bus;
      else if (page)
         seg_next = value_bus;
      else
         seg_next = status_bus;
   end

   // registered segment bus
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         seg_o <= '1;
      else
         seg_o <= seg_next;
   end

endmodule

// File: tb/tb_msg_pager.sv
// tb/tb_msg_pager.sv - directed self-checking bench for msg_pager
module tb_msg_pager;

   localparam int DIGITS   = 4;
   localparam int BIN_W    = 8;
   localparam int DWELL    = 16;
   localparam int BLINK    = 4;
   localparam int ALARM_TH = 50;

   localparam logic [31:0] BLANK    = 32'hFFFFFFFF;
   localparam logic [31:0] ST_5_3   = 32'h49FF0CFF;
   localparam logic [31:0] ST_5_4   = 32'h49FF98FF;
   localparam logic [31:0] ST_DASH  = 32'hFDFFFCFF;
   localparam logic [31:0] V_0      = 32'hFFFFFF03;
   localparam logic [31:0] V_7      = 32'hFFFFFF1F;
   localparam logic [31:0] V_10     = 32'hFFFF9F03;
   localparam logic [31:0] V_45     = 32'hFFFF9949;
   localparam logic [31:0] V_49     = 32'hFFFF9909;
   localparam logic [31:0] V_50     = 32'hFFFF4903;
   localparam logic [31:0] V_123    = 32'hFF9F250D;
   localparam logic [31:0] V_200    = 32'hFF250303;
   localparam logic [31:0] HOT      = 32'hD1C5E1FF;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              mode = 1'b0;
   logic [3:0]        s1 = 4'h0;
   logic [3:0]        s2 = 4'h0;
   logic [BIN_W-1:0]  value = '0;
   logic [8*DIGITS-1:0] seg;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   msg_pager #(
      .DIGITS(DIGITS), .BIN_W(BIN_W), .DWELL(DWELL), .BLINK(BLINK), .ALARM_TH(ALARM_TH)
   ) dut (
      .clk_i(clk), .rst_i(rst), .mode_i(mode), .state1_i(s1), .state2_i(s2),
      .value_i(value), .seg_o(seg)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; mode = 1'b1; s1 = 4'h3; s2 = 4'h5; value = 8'd123;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (seg !== BLANK) begin
         miscompares++;
         $display("FAIL reset_held got=%h exp=%h", seg, BLANK);
      end
      rst = 1'b0;
      cyc = 0;
      vectors++;
      if (seg !== BLANK) begin
         miscompares++;
         $display("FAIL reset_released got=%h exp=%h", seg, BLANK);
      end
      run_to(2);
      vectors++;
      if (seg !== ST_5_3) begin
         miscompares++;
         $display("FAIL first_status cyc=%0d got=%h exp=%h", cyc, seg, ST_5_3);
      end
   endtask

   task automatic test_alternation();
      logic [31:0] exp_a, exp_b;
      run_to(18);
      vectors++;
      if (seg !== ST_5_3) begin
         miscompares++;
         $display("FAIL status_end cyc=%0d got=%h exp=%h", cyc, seg, ST_5_3);
      end
      for (int c = 19; c <= 20; c++) begin
         run_to(c);
         vectors++;
         if (seg !== V_0) begin
            miscompares++;
            $display("FAIL first_value_zero cyc=%0d got=%h exp=%h", cyc, seg, V_0);
         end
      end
      run_to(21);
      vectors++;
      if (seg !== V_123) begin
         miscompares++;
         $display("FAIL first_value_123 cyc=%0d got=%h exp=%h", cyc, seg, V_123);
      end
      for (int b = 34; b <= 114; b += 16) begin
         exp_a = (((b - 34) / 16) % 2 == 0) ? V_123 : ST_5_3;
         exp_b = (((b - 34) / 16) % 2 == 0) ? ST_5_3 : V_123;
         run_to(b);
         vectors++;
         if (seg !== exp_a) begin
            miscompares++;
            $display("FAIL toggle_before cyc=%0d got=%h exp=%h", cyc, seg, exp_a);
         end
         run_to(b + 1);
         vectors++;
         if (seg !== exp_b) begin
            miscompares++;
            $display("FAIL toggle_after cyc=%0d got=%h exp=%h", cyc, seg, exp_b);
         end
      end
   endtask

   task automatic test_restart();
      s1 = 4'h4;
      run_to(117);
      vectors++;
      if (seg !== V_123) begin
         miscompares++;
         $display("FAIL restart_k1 cyc=%0d got=%h exp=%h", cyc, seg, V_123);
      end
      run_to(118);
      vectors++;
      if (seg !== ST_5_4) begin
         miscompares++;
         $display("FAIL restart_k2 cyc=%0d got=%h exp=%h", cyc, seg, ST_5_4);
      end
      run_to(133);
      vectors++;
      if (seg !== ST_5_4) begin
         miscompares++;
         $display("FAIL restart_dwell_end cyc=%0d got=%h exp=%h", cyc, seg, ST_5_4);
      end
      run_to(134);
      vectors++;
      if (seg !== V_123) begin
         miscompares++;
         $display("FAIL restart_value cyc=%0d got=%h exp=%h", cyc, seg, V_123);
      end
   endtask

   task automatic test_latency();
      value = 8'd7;
      run_to(145);
      vectors++;
      if (seg !== V_123) begin
         miscompares++;
         $display("FAIL lat7_before cyc=%0d got=%h exp=%h", cyc, seg, V_123);
      end
      run_to(146);
      vectors++;
      if (seg !== V_7) begin
         miscompares++;
         $display("FAIL lat7_after cyc=%0d got=%h exp=%h", cyc, seg, V_7);
      end
      run_to(166);
      vectors++;
      if (seg !== V_7) begin
         miscompares++;
         $display("FAIL lat_page7 cyc=%0d got=%h exp=%h", cyc, seg, V_7);
      end
      value = 8'd200;
      for (int c = 167; c <= 177; c++) begin
         run_to(c);
         vectors++;
         if (seg !== V_7) begin
            miscompares++;
            $display("FAIL lat200_hold cyc=%0d got=%h exp=%h", cyc, seg, V_7);
         end
      end
      run_to(178);
      vectors++;
      if (seg !== V_200) begin
         miscompares++;
         $display("FAIL lat200_k11 cyc=%0d got=%h exp=%h", cyc, seg, V_200);
      end
      value = 8'd0;
      run_to(197);
      vectors++;
      if (seg !== ST_5_4) begin
         miscompares++;
         $display("FAIL lat0_status cyc=%0d got=%h exp=%h", cyc, seg, ST_5_4);
      end
      run_to(198);
      vectors++;
      if (seg !== V_0) begin
         miscompares++;
         $display("FAIL lat0_value cyc=%0d got=%h exp=%h", cyc, seg, V_0);
      end
   endtask

   task automatic test_mid_conversion();
      logic [31:0] exp;
      value = 8'd10;
      run_to(199);
      value = 8'd99;
      run_to(200);
      value = 8'd45;
      for (int c = 201; c <= 213; c++) begin
         exp = (c < 210) ? V_0 : V_10;
         run_to(c);
         vectors++;
         if (seg !== exp) begin
            miscompares++;
            $display("FAIL midconv_seq cyc=%0d got=%h exp=%h", cyc, seg, exp);
         end
      end
      run_to(230);
      vectors++;
      if (seg !== V_45) begin
         miscompares++;
         $display("FAIL midconv_final cyc=%0d got=%h exp=%h", cyc, seg, V_45);
      end
   endtask

   task automatic test_alarm();
      logic [31:0] exp;
      s1 = 4'h0; s2 = 4'h0; value = 8'd49;
      run_to(232);
      value = 8'd50;
      for (int c = 233; c <= 234; c++) begin
         run_to(c);
         vectors++;
         if (seg !== ST_DASH) begin
            miscompares++;
            $display("FAIL alarm_pre cyc=%0d got=%h exp=%h", cyc, seg, ST_DASH);
         end
      end
      for (int c = 235; c <= 252; c++) begin
         exp = ((((c - 235) / 4) % 2) == 0) ? HOT : BLANK;
         run_to(c);
         vectors++;
         if (seg !== exp) begin
            miscompares++;
            $display("FAIL alarm_blink cyc=%0d got=%h exp=%h", cyc, seg, exp);
         end
         if (c == 250) value = 8'd49;
      end
      run_to(253);
      vectors++;
      if (seg !== V_50) begin
         miscompares++;
         $display("FAIL alarm_clear cyc=%0d got=%h exp=%h", cyc, seg, V_50);
      end
      run_to(262);
      vectors++;
      if (seg !== V_49) begin
         miscompares++;
         $display("FAIL alarm_value49 cyc=%0d got=%h exp=%h", cyc, seg, V_49);
      end
   endtask

   task automatic test_async_reset();
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (seg !== BLANK) begin
         miscompares++;
         $display("FAIL async_reset got=%h exp=%h", seg, BLANK);
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_alternation();
      test_restart();
      test_latency();
      test_mid_conversion();
      test_alarm();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
